// File: rtl/riscv_pkg.sv
// Shared RISC-V writeback types: register-file geometry, writeback request
// bundle, arbiter grant encoding and the "does this write reach the RF" rule.
package riscv_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned REG_DW = 32;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] waddr;
      logic [REG_DW-1:0] wdata;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } grant_e;

   // x0 is hard-wired to zero: transfers to it are accepted but never written.
   function automatic logic wb_writes_rf(input logic [REG_AW-1:0] waddr);
      return waddr != '0;
   endfunction

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way ALU/LSU writeback arbiter. RISCV_WB_RR_EN selects round-robin;
// otherwise fixed priority LSU over ALU with no last-grant state.
module riscv_rr_arb2
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   alu_valid_i,
   input  logic   lsu_valid_i,
   output grant_e grant_o
);

   logic contention;
   assign contention = alu_valid_i && lsu_valid_i;

`ifdef RISCV_WB_RR_EN
   grant_e last_q, last_d;

   always_comb begin
      grant_o = GNT_NONE;
      if (contention) begin
         grant_o = (last_q == GNT_LSU) ? GNT_ALU : GNT_LSU;
      end else if (lsu_valid_i) begin
         grant_o = GNT_LSU;
      end else if (alu_valid_i) begin
         grant_o = GNT_ALU;
      end
   end

   // History only moves on contention, so a lone requester never steals a turn.
   always_comb begin
      last_d = last_q;
      if (contention) begin
         last_d = grant_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= GNT_ALU;
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n ^ contention;

   always_comb begin
      grant_o = GNT_NONE;
      if (lsu_valid_i) begin
         grant_o = GNT_LSU;
      end else if (alu_valid_i) begin
         grant_o = GNT_ALU;
      end
   end
`endif

endmodule

// File: rtl/riscv_wb_arb.sv
// Register-file writeback arbiter: merges ALU and LSU writebacks into one
// registered write port. Policy set by RISCV_WB_RR_EN (see riscv_rr_arb2).
module riscv_wb_arb
   import riscv_pkg::*;
#(
   parameter int unsigned AW = REG_AW,
   parameter int unsigned DW = REG_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_alu_valid,
   input  logic [AW-1:0] i_alu_waddr,
   input  logic [DW-1:0] i_alu_wdata,
   output logic          o_alu_ready,
   input  logic          i_lsu_valid,
   input  logic [AW-1:0] i_lsu_waddr,
   input  logic [DW-1:0] i_lsu_wdata,
   output logic          o_lsu_ready,
   output logic          o_we,
   output logic [AW-1:0] o_waddr,
   output logic [DW-1:0] o_wdata,
   output logic [7:0]    o_stall_cnt
);

   wb_req_t       alu_req, lsu_req, sel_req;
   grant_e        grant;
   logic          alu_ready, lsu_ready, accept, stalled;

   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [7:0]    stall_q, stall_d;

   // Requests are carried in the package bundle; widths adapt by cast.
   assign alu_req = '{valid: i_alu_valid, waddr: REG_AW'(i_alu_waddr), wdata: REG_DW'(i_alu_wdata)};
   assign lsu_req = '{valid: i_lsu_valid, waddr: REG_AW'(i_lsu_waddr), wdata: REG_DW'(i_lsu_wdata)};

   riscv_rr_arb2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid_i (alu_req.valid),
      .lsu_valid_i (lsu_req.valid),
      .grant_o     (grant)
   );

   // Readies are masked by reset so nothing is accepted while held in reset.
   assign alu_ready = rst_n && (grant == GNT_ALU);
   assign lsu_ready = rst_n && (grant == GNT_LSU);
   assign accept    = alu_ready || lsu_ready;
   assign sel_req   = lsu_ready ? lsu_req : alu_req;
   assign stalled   = (alu_req.valid && !alu_ready) || (lsu_req.valid && !lsu_ready);

   always_comb begin
      we_d    = accept && wb_writes_rf(sel_req.waddr);
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (accept) begin
         waddr_d = AW'(sel_req.waddr);
         wdata_d = DW'(sel_req.wdata);
      end
      stall_d = stall_q;
      if (stalled && (stall_q != 8'hFF)) begin
         stall_d = stall_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         stall_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         stall_q <= stall_d;
      end
   end

   assign o_alu_ready = alu_ready;
   assign o_lsu_ready = lsu_ready;
   assign o_we        = we_q;
   assign o_waddr     = waddr_q;
   assign o_wdata     = wdata_q;
   assign o_stall_cnt = stall_q;

endmodule
